// File: rtl/mem_ctrl_32x8_if.sv
// Bus between the memory test driver (master) and the memory controller (slave).
interface mem_ctrl_32x8_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              clear;
  logic              busy;
  logic [1:0]        err_flags;
  logic              err_clr;

  // Driver side: issues requests, observes data and status.
  modport master (
    output read, write, addr, data_in, clear, err_clr,
    input  data_out, rd_valid, busy, err_flags
  );

  // Memory side: consumes requests, returns data and status.
  modport slave (
    input  read, write, addr, data_in, clear, err_clr,
    output data_out, rd_valid, busy, err_flags
  );
endinterface

// File: rtl/mem_ctrl_32x8.sv
// Single-port synchronous memory with registered read, a bulk-clear engine
// that walks every word writing INIT_VAL, and sticky protocol-error flags.
module mem_ctrl_32x8 #(
  parameter int                 ADDR_W   = 5,
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_ctrl_32x8_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;
  logic [1:0]        err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Decoded request qualifiers; clear in IDLE swallows any access silently.
  logic idle_access;
  logic do_write;
  logic do_read;
  logic mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic last_word;

  // State register and clear address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: start on clear in IDLE, leave INIT after the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.clear) state_d = ST_INIT;
      end
      ST_INIT: begin
        cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (last_word) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output/decode logic: array port control and error detection per state.
  always_comb begin
    last_word   = (cnt_q == {ADDR_W{1'b1}});
    idle_access = (state_q == ST_IDLE) && !bus.clear;
    do_write    = idle_access && bus.write && !bus.read;
    do_read     = idle_access && bus.read && !bus.write;
    mem_we      = do_write || (state_q == ST_INIT);
    mem_waddr   = (state_q == ST_INIT) ? cnt_q : bus.addr;
    mem_wdata   = (state_q == ST_INIT) ? INIT_VAL : bus.data_in;
    // Clearing first lets an error on the same edge win.
    err_d       = bus.err_clr ? 2'b00 : err_q;
    if (idle_access && bus.read && bus.write) err_d[0] = 1'b1;
    if ((state_q == ST_INIT) && (bus.read || bus.write)) err_d[1] = 1'b1;
  end

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Registered read port with a one-cycle valid strobe; data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= do_read;
      if (do_read) data_out_q <= mem_q[bus.addr];
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 2'b00;
    else        err_q <= err_d;
  end

  assign bus.data_out  = data_out_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy      = (state_q == ST_INIT);
  assign bus.err_flags = err_q;

endmodule

// File: tb/tb_mem_ctrl_32x8.sv
// Directed testbench for mem_ctrl_32x8 with hand-computed expectations.
module tb_mem_ctrl_32x8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_ctrl_32x8_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  mem_ctrl_32x8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s value=%0h", tag, obs);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    bus.write = 1'b1; bus.addr = a; bus.data_in = d;
    step();
    bus.write = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [7:0] exp, input string tag);
    bus.read = 1'b1; bus.addr = a;
    step();
    bus.read = 1'b0;
    check_eq({tag, "_data"}, {24'd0, bus.data_out}, {24'd0, exp});
    check_eq({tag, "_valid"}, {31'd0, bus.rd_valid}, 32'd1);
  endtask

  // Wait for busy to drop, bounded; returns number of busy cycles seen.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      step();
    end
  endtask

  int n;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.read = 0; bus.write = 0; bus.addr = '0; bus.data_in = '0;
    bus.clear = 0; bus.err_clr = 0;
    step(); step();
    check_eq("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    check_eq("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check_eq("rst_busy",     {31'd0, bus.busy},     32'd0);
    check_eq("rst_err",      {30'd0, bus.err_flags}, 32'd0);
    rst_n = 1'b1;
    step();

    // Write/readback of the identity pattern.
    for (int i = 0; i < 32; i++) do_write(5'(i), 8'(i));
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i), 8'(i), $sformatf("wr_rd%0d", i));
      check_eq($sformatf("wr_rd%0d_err", i), {30'd0, bus.err_flags}, 32'd0);
    end

    // Latency and hold.
    do_write(5'd3, 8'hA5);
    do_read(5'd3, 8'hA5, "lat_t1");
    step();
    check_eq("hold_valid", {31'd0, bus.rd_valid}, 32'd0);
    check_eq("hold_data",  {24'd0, bus.data_out}, 32'hA5);

    // Read and write together.
    bus.read = 1; bus.write = 1; bus.addr = 5'd7; bus.data_in = 8'hFF;
    step();
    bus.read = 0; bus.write = 0;
    check_eq("conf_err",   {30'd0, bus.err_flags}, 32'd1);
    check_eq("conf_valid", {31'd0, bus.rd_valid},  32'd0);
    check_eq("conf_data",  {24'd0, bus.data_out},  32'hA5);
    do_read(5'd7, 8'h07, "conf_mem7");
    bus.err_clr = 1; step(); bus.err_clr = 0;
    check_eq("conf_errclr", {30'd0, bus.err_flags}, 32'd0);

    // Clear engine with a write attempted while busy.
    do_write(5'd3, 8'd3);
    bus.clear = 1; step(); bus.clear = 0;
    check_eq("clr_busy_start", {31'd0, bus.busy}, 32'd1);
    n = 0;
    while (bus.busy && n < 100) begin
      if (n == 0) begin bus.write = 1; bus.addr = 5'd5; bus.data_in = 8'h99; end
      n++;
      step();
      bus.write = 0;
    end
    check_eq("clr_busy_cycles", n, 32'd32);
    check_eq("clr_err_busy", {30'd0, bus.err_flags}, 32'd2);
    bus.err_clr = 1; step(); bus.err_clr = 0;
    check_eq("clr_errclr", {30'd0, bus.err_flags}, 32'd0);
    for (int i = 0; i < 32; i++) do_read(5'(i), 8'h00, $sformatf("clr_rd%0d", i));

    // Reset in the middle of INIT.
    for (int i = 0; i < 32; i++) do_write(5'(i), 8'(i));
    bus.clear = 1; step(); bus.clear = 0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    check_eq("midrst_busy_after", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 32; i++)
      do_read(5'(i), (i < 10) ? 8'h00 : 8'(i), $sformatf("midrst_rd%0d", i));

    // Clear takes priority over a write on the same edge.
    bus.clear = 1; bus.write = 1; bus.addr = 5'd2; bus.data_in = 8'h55;
    step();
    bus.clear = 0; bus.write = 0;
    check_eq("prio_busy", {31'd0, bus.busy}, 32'd1);
    check_eq("prio_err",  {30'd0, bus.err_flags}, 32'd0);
    wait_idle(n);
    check_eq("prio_cycles", n, 32'd32);
    do_read(5'd2, 8'h00, "prio_mem2");
    check_eq("prio_err_end", {30'd0, bus.err_flags}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
